arithmetic_rs: RTL and testbench
================================

# arithmetic_rs

Reservation station directly upstream of `arithmetic_FU`. It accepts dispatched arithmetic micro-ops whose source operands may still be pending, captures operand values from the common data bus (CDB) as producers complete, and issues the oldest fully-ready entry to the FU. The FU accepts one op every cycle with no back-pressure, so at most one entry issues per cycle.

## Interface
- `XLEN`, 32, operand width.
- `DEPTH`, 4, number of entries (≥2).
- `TAG_W`, 6, physical/ROB tag width.
- `CNT_W`, $clog2(DEPTH+1), occupancy counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear of all entries.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  equals `count < DEPTH`.
- `disp_additional_info`  in  1  passed through to the FU unchanged.
- `disp_arithmetic_type`  in  3  passed through to the FU unchanged.
- `disp_rob_tag`  in  TAG_W  destination tag.
- `disp_rs1_rdy`, `disp_rs2_rdy`  in  1  operand value is already valid.
- `disp_rs1_tag`, `disp_rs2_tag`  in  TAG_W  producer tag when not ready.
- `disp_rs1_val`, `disp_rs2_val`  in  XLEN  operand value when ready.
- `cdb_valid`  in  1  broadcast valid.
- `cdb_tag`  in  TAG_W  broadcast tag.
- `cdb_data`  in  XLEN  broadcast value.
- `issue_valid`  out  1  drives FU `valid_in`.
- `issue_additional_info`  out  1  drives FU `additional_info`.
- `issue_arithmetic_type`  out  3  drives FU `arithmetic_type`.
- `issue_rs1`, `issue_rs2`  out  XLEN  drive FU `rs1` / `rs2`.
- `issue_rob_tag`  out  TAG_W  tag that travels alongside the FU result.
- `count`  out  CNT_W  number of occupied entries.

## Operation
- Storage is a collapsing queue: entry 0 is the oldest, and occupied entries are always contiguous from index 0.
- Each entry holds: type, info, rob_tag, and for each operand a ready bit, a tag and a value.
- Dispatch is accepted when `disp_valid && disp_ready`. After any collapse, the new entry is written at index `count - issued`.
- Wakeup: every valid entry compares each not-ready operand's tag against `cdb_tag` when `cdb_valid` is high. On a match, the entry stores `cdb_data` and sets the operand's ready bit.
- Dispatch wakeup: if an operand dispatched not-ready has a tag equal to the same-cycle CDB tag, it is written as ready with `cdb_data`.
- Select: the lowest-index entry whose registered ready bits are both 1.
  - `issue_*` are driven combinationally from that entry.
  - `issue_valid` is 1 when such an entry exists.
- Remove: the selected entry is removed at the clock edge, and all younger entries shift down by one.
- `count` next value = `count + accept - issue`.
- `flush` empties the queue, sets `count` to 0 and blocks any same-cycle dispatch. `flush` has priority over dispatch and over issue state updates; `issue_valid` may still be high combinationally in the flush cycle.
- When `issue_valid` is 0, the `issue_*` data outputs are 0.

## Timing
- Reset (`rst` low): all entries invalid, `count` = 0, `issue_valid` = 0, all `issue_*` = 0, `disp_ready` = 1. Reset mid-operation discards every entry immediately and asynchronously.
- Dispatch of an op with both operands ready at edge E issues during the cycle after E. The FU result follows one cycle later.
- An operand woken by the CDB at edge E makes its entry eligible during the cycle after E (unless the macro under Configuration is defined).
- `disp_ready` depends only on registered `count`. A full queue does not accept a dispatch even in a cycle where an issue occurs.
- One issue per cycle, strictly in age order among ready entries.
- One dispatch per cycle.

## Configuration
- `ARITH_RS_WAKEUP_FWD_EN` defined: an entry whose only missing operands match the current-cycle CDB broadcast is eligible to issue in that same cycle.
  - `cdb_data` is forwarded onto `issue_rs1` / `issue_rs2` for the matching operands.
  - Age priority still applies, with forwarded-eligible entries treated as ready.
- `ARITH_RS_WAKEUP_FWD_EN` undefined: eligibility uses registered ready bits only, adding one cycle of wakeup-to-issue latency.

## Test plan
- Reset then idle → `count`=0, `issue_valid`=0, `disp_ready`=1; release `rst` mid-cycle, no spurious issue.
- Dispatch ADD rs1=0x00000001, rs2=0x00000001, both ready, tag 5 → next cycle `issue_valid`=1, `issue_rs1`=1, `issue_rob_tag`=5; FU result 0x00000002 the cycle after.
- Dispatch SUB (info=1) with rs2 pending on tag 9, then CDB tag 9 data 0x00000002, with rs1=0x00000001 → issues the cycle after the broadcast (same cycle with the macro defined), `issue_rs2`=2, FU result 0xFFFFFFFF.
- Fill 4 entries with only entry 2 ready → `disp_ready`=0, entry 2 issues, younger entry shifts to index 2, `count`=3, `disp_ready`=1 next cycle.
- Two ready entries, tags 3 (older) and 4 → tag 3 issues first and tag 4 on the next cycle; a dispatch with `rdy`=0 whose tag equals the same-cycle CDB tag is captured as ready.
- Assert `flush` with 3 entries plus a concurrent dispatch → `count`=0 next cycle, and no later issue of any flushed op.

Source files
------------

// File: rtl/arithmetic_rs.sv
// arithmetic_rs: collapsing-queue reservation station feeding arithmetic_FU.
// Holds dispatched arithmetic micro-ops, captures operands from the CDB and
// issues the oldest fully-ready entry (at most one per cycle).
//
// Optional feature macro: ARITH_RS_WAKEUP_FWD_EN
//   defined   -> an entry whose missing operands match the current CDB
//                broadcast may issue in that same cycle (cdb_data forwarded)
//   undefined -> eligibility uses registered ready bits only
//
// Ports:
//   clk, rst (async active-low), flush (sync clear)
//   disp_*   : dispatch request / operand info, disp_ready handshake
//   cdb_*    : common data bus broadcast
//   issue_*  : combinational issue bundle to the FU
//   count    : number of occupied entries
module arithmetic_rs #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic             disp_additional_info,
    input  logic [2:0]       disp_arithmetic_type,
    input  logic [TAG_W-1:0] disp_rob_tag,
    input  logic             disp_rs1_rdy,
    input  logic             disp_rs2_rdy,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic [XLEN-1:0]  disp_rs1_val,
    input  logic [XLEN-1:0]  disp_rs2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             issue_valid,
    output logic             issue_additional_info,
    output logic [2:0]       issue_arithmetic_type,
    output logic [XLEN-1:0]  issue_rs1,
    output logic [XLEN-1:0]  issue_rs2,
    output logic [TAG_W-1:0] issue_rob_tag,
    output logic [CNT_W-1:0] count
);

    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]       typ;
        logic             info;
        logic [TAG_W-1:0] rob;
        logic             r1;
        logic [TAG_W-1:0] t1;
        logic [XLEN-1:0]  v1;
        logic             r2;
        logic [TAG_W-1:0] t2;
        logic [XLEN-1:0]  v2;
    } ent_t;

    ent_t             r_q   [DEPTH];
    ent_t             w_nq  [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_wr_idx;
    logic [CNT_W-1:0] w_count_nxt;
    logic [DEPTH-1:0] w_vld;
    logic [DEPTH-1:0] w_f1;
    logic [DEPTH-1:0] w_f2;
    logic [DEPTH-1:0] w_elig;
    logic [SEL_W-1:0] w_sel;
    logic             w_issue;
    logic             w_acc;
    ent_t             w_new;
    ent_t             w_e;

    assign count      = r_count;
    assign disp_ready = (r_count < CNT_W'(DEPTH));
    assign w_acc      = disp_valid && disp_ready && !flush;

    // Eligibility; the forward terms let a same-cycle CDB match count as ready.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_vld[i] = (i < int'(r_count));
`ifdef ARITH_RS_WAKEUP_FWD_EN
            w_f1[i] = cdb_valid && !r_q[i].r1 && (r_q[i].t1 == cdb_tag);
            w_f2[i] = cdb_valid && !r_q[i].r2 && (r_q[i].t2 == cdb_tag);
`else
            w_f1[i] = 1'b0;
            w_f2[i] = 1'b0;
`endif
            w_elig[i] = w_vld[i] && (r_q[i].r1 || w_f1[i])
                                 && (r_q[i].r2 || w_f2[i]);
        end
    end

    // Oldest-first select: scanning downward leaves the lowest index.
    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_issue = 1'b1;
                w_sel   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        issue_valid           = w_issue;
        issue_additional_info = 1'b0;
        issue_arithmetic_type = '0;
        issue_rs1             = '0;
        issue_rs2             = '0;
        issue_rob_tag         = '0;
        if (w_issue) begin
            issue_additional_info = r_q[w_sel].info;
            issue_arithmetic_type = r_q[w_sel].typ;
            issue_rob_tag         = r_q[w_sel].rob;
            issue_rs1 = w_f1[w_sel] ? cdb_data : r_q[w_sel].v1;
            issue_rs2 = w_f2[w_sel] ? cdb_data : r_q[w_sel].v2;
        end
    end

    // New entry, with wakeup from a same-cycle CDB broadcast.
    always_comb begin
        w_new.typ  = disp_arithmetic_type;
        w_new.info = disp_additional_info;
        w_new.rob  = disp_rob_tag;
        w_new.r1   = disp_rs1_rdy;
        w_new.t1   = disp_rs1_tag;
        w_new.v1   = disp_rs1_val;
        w_new.r2   = disp_rs2_rdy;
        w_new.t2   = disp_rs2_tag;
        w_new.v2   = disp_rs2_val;
        if (!disp_rs1_rdy && cdb_valid && (disp_rs1_tag == cdb_tag)) begin
            w_new.r1 = 1'b1;
            w_new.v1 = cdb_data;
        end
        if (!disp_rs2_rdy && cdb_valid && (disp_rs2_tag == cdb_tag)) begin
            w_new.r2 = 1'b1;
            w_new.v2 = cdb_data;
        end
    end

    assign w_wr_idx    = r_count - CNT_W'(w_issue);
    assign w_count_nxt = r_count + CNT_W'(w_acc) - CNT_W'(w_issue);

    // Collapse above the issued slot, wake up, then append the new entry.
    always_comb begin
        w_e = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_e = r_q[i];
            if (w_issue && (i >= int'(w_sel)) && (i < DEPTH - 1)) begin
                w_e = r_q[i+1];
            end
            if (cdb_valid && !w_e.r1 && (w_e.t1 == cdb_tag)) begin
                w_e.r1 = 1'b1;
                w_e.v1 = cdb_data;
            end
            if (cdb_valid && !w_e.r2 && (w_e.t2 == cdb_tag)) begin
                w_e.r2 = 1'b1;
                w_e.v2 = cdb_data;
            end
            if (w_acc && (i == int'(w_wr_idx))) begin
                w_e = w_new;
            end
            w_nq[i] = w_e;
        end
    end

    // Entry contents beyond count are don't-care, so flush only clears count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            r_count <= flush ? '0 : w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nq[i];
            end
        end
    end

endmodule

// File: tb/tb_arithmetic_rs.sv
// tb_arithmetic_rs: directed self-checking bench for arithmetic_rs.
// Works with or without ARITH_RS_WAKEUP_FWD_EN defined.
module tb_arithmetic_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic        disp_additional_info;
    logic [2:0]  disp_arithmetic_type;
    logic [5:0]  disp_rob_tag;
    logic        disp_rs1_rdy;
    logic        disp_rs2_rdy;
    logic [5:0]  disp_rs1_tag;
    logic [5:0]  disp_rs2_tag;
    logic [31:0] disp_rs1_val;
    logic [31:0] disp_rs2_val;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic        issue_additional_info;
    logic [2:0]  issue_arithmetic_type;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic [5:0]  issue_rob_tag;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arithmetic_rs dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .disp_valid           (disp_valid),
        .disp_ready           (disp_ready),
        .disp_additional_info (disp_additional_info),
        .disp_arithmetic_type (disp_arithmetic_type),
        .disp_rob_tag         (disp_rob_tag),
        .disp_rs1_rdy         (disp_rs1_rdy),
        .disp_rs2_rdy         (disp_rs2_rdy),
        .disp_rs1_tag         (disp_rs1_tag),
        .disp_rs2_tag         (disp_rs2_tag),
        .disp_rs1_val         (disp_rs1_val),
        .disp_rs2_val         (disp_rs2_val),
        .cdb_valid            (cdb_valid),
        .cdb_tag              (cdb_tag),
        .cdb_data             (cdb_data),
        .issue_valid          (issue_valid),
        .issue_additional_info(issue_additional_info),
        .issue_arithmetic_type(issue_arithmetic_type),
        .issue_rs1            (issue_rs1),
        .issue_rs2            (issue_rs2),
        .issue_rob_tag        (issue_rob_tag),
        .count                (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [2:0] ty, input logic inf,
                       input logic [5:0] tag,
                       input logic r1, input logic [5:0] t1,
                       input logic [31:0] v1,
                       input logic r2, input logic [5:0] t2,
                       input logic [31:0] v2);
        disp_valid           = 1'b1;
        disp_arithmetic_type = ty;
        disp_additional_info = inf;
        disp_rob_tag         = tag;
        disp_rs1_rdy         = r1;
        disp_rs1_tag         = t1;
        disp_rs1_val         = v1;
        disp_rs2_rdy         = r2;
        disp_rs2_tag         = t2;
        disp_rs2_val         = v2;
    endtask

    task automatic cdb(input logic v, input logic [5:0] t,
                       input logic [31:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        disp_valid = 1'b0;
        drv(3'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        disp_valid = 1'b0;
        cdb(1'b0, 6'd0, 32'd0);
        #2;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rst_ivalid got=%0b exp=0", issue_valid); end
        checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL rst_dready got=%0b exp=1", disp_ready); end
        checks++; if (issue_rs1 !== 32'd0 || issue_rob_tag !== 6'd0) begin failures++; $display("FAIL rst_idata got=%0h/%0h exp=0/0", issue_rs1, issue_rob_tag); end
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL rst_idle got=%0b/%0d exp=0/0", issue_valid, count); end
    endtask

    task automatic test_add();
        drv(3'd0, 1'b0, 6'd5, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL add_pre got=%0b exp=0", issue_valid); end
        tick();
        disp_valid = 1'b0;
        checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", issue_valid); end
        checks++; if (issue_rs1 !== 32'h1 || issue_rs2 !== 32'h1) begin failures++; $display("FAIL add_ops got=%0h/%0h exp=1/1", issue_rs1, issue_rs2); end
        checks++; if (issue_rob_tag !== 6'd5 || count !== 3'd1) begin failures++; $display("FAIL add_tag got=%0d/%0d exp=5/1", issue_rob_tag, count); end
        checks++; if (issue_rs1 + issue_rs2 !== 32'h2) begin failures++; $display("FAIL add_res got=%0h exp=2", issue_rs1 + issue_rs2); end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL add_done got=%0b/%0d exp=0/0", issue_valid, count); end
    endtask

    task automatic test_wakeup();
        drv(3'd1, 1'b1, 6'd7, 1'b1, 6'd0, 32'h1, 1'b0, 6'd9, 32'h0);
        tick();
        disp_valid = 1'b0;
        checks++; if (issue_valid !== 1'b0 || count !== 3'd1) begin failures++; $display("FAIL wk_wait got=%0b/%0d exp=0/1", issue_valid, count); end
        cdb(1'b1, 6'd9, 32'h2);
`ifdef ARITH_RS_WAKEUP_FWD_EN
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rs2 !== 32'h2) begin failures++; $display("FAIL wk_fwd got=%0b/%0h exp=1/2", issue_valid, issue_rs2); end
        checks++; if (issue_rs1 - issue_rs2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wk_res got=%0h exp=ffffffff", issue_rs1 - issue_rs2); end
        tick();
        cdb(1'b0, 6'd0, 32'd0);
`else
        #1;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wk_early got=%0b exp=0", issue_valid); end
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        checks++; if (issue_valid !== 1'b1 || issue_rs2 !== 32'h2) begin failures++; $display("FAIL wk_issue got=%0b/%0h exp=1/2", issue_valid, issue_rs2); end
        checks++; if (issue_additional_info !== 1'b1 || issue_arithmetic_type !== 3'd1 || issue_rob_tag !== 6'd7) begin failures++; $display("FAIL wk_fields got=%0b/%0d/%0d exp=1/1/7", issue_additional_info, issue_arithmetic_type, issue_rob_tag); end
        checks++; if (issue_rs1 - issue_rs2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wk_res got=%0h exp=ffffffff", issue_rs1 - issue_rs2); end
        tick();
`endif
        checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL wk_done got=%0b/%0d exp=0/0", issue_valid, count); end
    endtask

    task automatic test_full();
        drv(3'd0, 1'b0, 6'd10, 1'b0, 6'd20, 32'h0, 1'b1, 6'd0, 32'h10);
        tick();
        drv(3'd0, 1'b0, 6'd11, 1'b0, 6'd21, 32'h0, 1'b1, 6'd0, 32'h11);
        tick();
        drv(3'd2, 1'b0, 6'd12, 1'b0, 6'd30, 32'h0, 1'b1, 6'd0, 32'h12);
        tick();
        drv(3'd0, 1'b0, 6'd13, 1'b0, 6'd23, 32'h0, 1'b1, 6'd0, 32'h13);
        tick();
        disp_valid = 1'b0;
        checks++; if (count !== 3'd4 || disp_ready !== 1'b0) begin failures++; $display("FAIL full_cnt got=%0d/%0b exp=4/0", count, disp_ready); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL full_idle got=%0b exp=0", issue_valid); end
        drv(3'd0, 1'b0, 6'd40, 1'b1, 6'd0, 32'h99, 1'b1, 6'd0, 32'h99);
        cdb(1'b1, 6'd30, 32'h33);
`ifdef ARITH_RS_WAKEUP_FWD_EN
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd12 || issue_rs1 !== 32'h33) begin failures++; $display("FAIL full_iss got=%0b/%0d/%0h exp=1/12/33", issue_valid, issue_rob_tag, issue_rs1); end
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        disp_valid = 1'b0;
`else
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd12 || issue_rs1 !== 32'h33) begin failures++; $display("FAIL full_iss got=%0b/%0d/%0h exp=1/12/33", issue_valid, issue_rob_tag, issue_rs1); end
        checks++; if (count !== 3'd4 || disp_ready !== 1'b0) begin failures++; $display("FAIL full_rej got=%0d/%0b exp=4/0", count, disp_ready); end
        tick();
        disp_valid = 1'b0;
`endif
        checks++; if (count !== 3'd3 || disp_ready !== 1'b1 || issue_valid !== 1'b0) begin failures++; $display("FAIL full_after got=%0d/%0b/%0b exp=3/1/0", count, disp_ready, issue_valid); end
        cdb(1'b1, 6'd23, 32'h55);
`ifdef ARITH_RS_WAKEUP_FWD_EN
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd13) begin failures++; $display("FAIL full_shift got=%0b/%0d exp=1/13", issue_valid, issue_rob_tag); end
        tick();
        cdb(1'b0, 6'd0, 32'd0);
`else
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd13 || issue_rs1 !== 32'h55) begin failures++; $display("FAIL full_shift got=%0b/%0d/%0h exp=1/13/55", issue_valid, issue_rob_tag, issue_rs1); end
        tick();
`endif
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL full_cnt2 got=%0d exp=2", count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin failures++; $display("FAIL full_clr got=%0d/%0b exp=0/0", count, issue_valid); end
    endtask

    task automatic test_back_to_back();
        drv(3'd0, 1'b0, 6'd3, 1'b0, 6'd60, 32'h0, 1'b1, 6'd0, 32'h3);
        tick();
        drv(3'd0, 1'b0, 6'd4, 1'b0, 6'd60, 32'h0, 1'b1, 6'd0, 32'h4);
        tick();
        drv(3'd0, 1'b0, 6'd6, 1'b0, 6'd60, 32'h0, 1'b1, 6'd0, 32'h6);
        cdb(1'b1, 6'd60, 32'hAB);
`ifdef ARITH_RS_WAKEUP_FWD_EN
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd3 || issue_rs1 !== 32'hAB) begin failures++; $display("FAIL b2b_first got=%0b/%0d/%0h exp=1/3/ab", issue_valid, issue_rob_tag, issue_rs1); end
        tick();
        disp_valid = 1'b0;
        cdb(1'b0, 6'd0, 32'd0);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_cnt got=%0d exp=2", count); end
`else
        #1;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%0b exp=0", issue_valid); end
        tick();
        disp_valid = 1'b0;
        cdb(1'b0, 6'd0, 32'd0);
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL b2b_cnt got=%0d exp=3", count); end
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd3 || issue_rs1 !== 32'hAB) begin failures++; $display("FAIL b2b_first got=%0b/%0d/%0h exp=1/3/ab", issue_valid, issue_rob_tag, issue_rs1); end
        tick();
`endif
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd4 || issue_rs2 !== 32'h4) begin failures++; $display("FAIL b2b_second got=%0b/%0d/%0h exp=1/4/4", issue_valid, issue_rob_tag, issue_rs2); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_tag !== 6'd6 || issue_rs1 !== 32'hAB) begin failures++; $display("FAIL b2b_capture got=%0b/%0d/%0h exp=1/6/ab", issue_valid, issue_rob_tag, issue_rs1); end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL b2b_done got=%0b/%0d exp=0/0", issue_valid, count); end
    endtask

    task automatic test_flush();
        drv(3'd0, 1'b0, 6'd50, 1'b0, 6'd40, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        drv(3'd0, 1'b0, 6'd51, 1'b0, 6'd41, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        drv(3'd0, 1'b0, 6'd52, 1'b0, 6'd42, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL fl_pre got=%0d exp=3", count); end
        drv(3'd0, 1'b0, 6'd53, 1'b1, 6'd0, 32'h7, 1'b1, 6'd0, 32'h7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        checks++; if (count !== 3'd0 || issue_valid !== 1'b0) begin failures++; $display("FAIL fl_clr got=%0d/%0b exp=0/0", count, issue_valid); end
        for (int k = 0; k < 3; k++) begin
            cdb(1'b1, 6'(40 + k), 32'h1);
            tick();
            checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL fl_ghost%0d got=%0b/%0d exp=0", k, issue_valid, issue_rob_tag); end
        end
        cdb(1'b0, 6'd0, 32'd0);
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL fl_end got=%0b/%0d exp=0/0", issue_valid, count); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wakeup();
        test_full();
        test_back_to_back();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
